// File: rtl/arbiter_rr_n.sv
// rtl/arbiter_rr_n.sv - N-host round-robin arbiter onto a single register bus
// One access in flight; per-host mask, run-time timeout, grant id and error flags.
module arbiter_rr_n #(
  parameter int NH = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int TW = 16,
  localparam int GW = $clog2(NH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NH-1:0]    hrd,
  input  logic [NH-1:0]    hwr,
  input  logic [NH*AW-1:0] haddr,
  input  logic [NH*BW-1:0] hbe,
  input  logic [NH*DW-1:0] hdwr,
  input  logic [NH-1:0]    hcpu,
  output logic [NH-1:0]    hdone,
  output logic [NH-1:0]    herr,
  output logic [DW-1:0]    hdrd,
  input  logic [NH-1:0]    req_mask,
  input  logic [TW-1:0]    tmo_limit,
  output logic [AW-1:0]    add_bus,
  output logic [BW-1:0]    byte_en,
  output logic [DW-1:0]    data_bus_wr,
  output logic             cpu_bus,
  output logic             wr_bus,
  output logic             rd_bus,
  input  logic [DW-1:0]    data_bus_rd,
  input  logic             ack_bus,
  output logic [GW-1:0]    grant_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t          state, state_nxt;
  logic [NH-1:0]   req;
  logic            any_req;
  logic [GW-1:0]   last;
  logic [GW-1:0]   win;
  logic            win_found;
  logic [AW-1:0]   sel_addr;
  logic [BW-1:0]   sel_be;
  logic [DW-1:0]   sel_dwr;
  logic            sel_cpu;
  logic            sel_rd;
  logic [TW-1:0]   cnt;
  logic            tmo_hit;
  logic            acc_end;
  logic            tmo_taken;

  assign req     = (hrd | hwr) & req_mask;
  assign any_req = |req;
  assign tmo_hit = (tmo_limit != '0) && (cnt == tmo_limit - TW'(1));
  assign acc_end = ack_bus || tmo_hit;

  // Search upward from the host after the last one served, wrapping at NH.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NH; k++) begin
      logic [GW-1:0] idx;
      idx = GW'((int'(last) + k) % NH);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_be   = '0;
    sel_dwr  = '0;
    sel_cpu  = 1'b0;
    sel_rd   = 1'b0;
    for (int i = 0; i < NH; i++) begin
      if (win == GW'(i)) begin
        sel_addr = haddr[i*AW +: AW];
        sel_be   = hbe[i*BW +: BW];
        sel_dwr  = hdwr[i*DW +: DW];
        sel_cpu  = hcpu[i];
        sel_rd   = hrd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (any_req) state_nxt = sel_rd ? RD : WR;
        else         state_nxt = IDLE;
      end
      WR, RD: begin
        if (acc_end) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last        <= GW'(NH - 1);
      grant_id    <= '0;
      add_bus     <= '0;
      byte_en     <= '0;
      data_bus_wr <= '0;
      cpu_bus     <= 1'b0;
      cnt         <= '0;
      tmo_taken   <= 1'b0;
      hdrd        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (any_req) begin
            add_bus     <= sel_addr;
            byte_en     <= sel_be;
            data_bus_wr <= sel_dwr;
            cpu_bus     <= sel_cpu;
            grant_id    <= win;
            last        <= win;
            cnt         <= '0;
          end
        end
        WR, RD: begin
          if (acc_end) begin
            add_bus     <= '0;
            byte_en     <= '0;
            data_bus_wr <= '0;
            cpu_bus     <= 1'b0;
            tmo_taken   <= !ack_bus;
          end else if (cnt != '1) begin
            cnt <= cnt + TW'(1);
          end
        end
        default: ;
      endcase
      if (state == RD && ack_bus) hdrd <= data_bus_rd;
    end
  end

  always_comb begin
    wr_bus = (state == WR);
    rd_bus = (state == RD);
    busy   = (state == WR) || (state == RD);
    hdone  = '0;
    herr   = '0;
    for (int i = 0; i < NH; i++) begin
      hdone[i] = (state == DONE) && (grant_id == GW'(i));
      herr[i]  = (state == DONE) && (grant_id == GW'(i)) && tmo_taken;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_n.sv
// tb/tb_arbiter_rr_n.sv - randomized self-checking bench for arbiter_rr_n
// Transaction-level model: grant, access length, timeout and read data.
module tb_arbiter_rr_n;
  localparam int NH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TW = 16;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NH-1:0]    hrd, hwr, hcpu, hdone, herr, req_mask;
  logic [NH*AW-1:0] haddr;
  logic [NH*BW-1:0] hbe;
  logic [NH*DW-1:0] hdwr;
  logic [DW-1:0]    hdrd, data_bus_wr, data_bus_rd;
  logic [TW-1:0]    tmo_limit;
  logic [AW-1:0]    add_bus;
  logic [BW-1:0]    byte_en;
  logic             cpu_bus, wr_bus, rd_bus, ack_bus, busy;
  logic [GW-1:0]    grant_id;

  always #5 clk = ~clk;

  arbiter_rr_n #(.NH(NH), .AW(AW), .DW(DW), .BW(BW), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n), .hrd(hrd), .hwr(hwr), .haddr(haddr), .hbe(hbe),
    .hdwr(hdwr), .hcpu(hcpu), .hdone(hdone), .herr(herr), .hdrd(hdrd),
    .req_mask(req_mask), .tmo_limit(tmo_limit), .add_bus(add_bus), .byte_en(byte_en),
    .data_bus_wr(data_bus_wr), .cpu_bus(cpu_bus), .wr_bus(wr_bus), .rd_bus(rd_bus),
    .data_bus_rd(data_bus_rd), .ack_bus(ack_bus), .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  int            last = NH - 1;
  bit            in_acc = 0;
  int            n, host, delay;
  bit            is_rd;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_dwr;
  logic          m_cpu;
  logic [DW-1:0] exp_hdrd = '0;
  int            exp_gid = 0;
  bit            exp_done, exp_err;
  int            dmin = 1, dmax = 6, stray_pct = 0, rst_pct = 0;
  bit            force_rst = 0;
  int            grants[NH];
  int            timeouts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int l, input logic [NH-1:0] r);
    for (int k = 1; k <= NH; k++) begin
      if (r[(l + k) % NH]) return (l + k) % NH;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [NH-1:0] r;
    @(posedge clk);
    #1;
    exp_done = 0;
    exp_err  = 0;
    if (!reset_n) begin
      in_acc   = 0;
      last     = NH - 1;
      exp_hdrd = '0;
      exp_gid  = 0;
    end else if (in_acc) begin
      if (ack_bus || (tmo_limit != 0 && n == int'(tmo_limit))) begin
        exp_done = 1;
        exp_err  = !ack_bus;
        in_acc   = 0;
        if (exp_err) timeouts++;
        if (is_rd && ack_bus) exp_hdrd = data_bus_rd;
      end else begin
        n++;
      end
    end else begin
      r = (hrd | hwr) & req_mask;
      if (r != 0) begin
        host    = rr(last, r);
        last    = host;
        exp_gid = host;
        grants[host]++;
        in_acc  = 1;
        n       = 1;
        is_rd   = hrd[host];
        m_addr  = haddr[host*AW +: AW];
        m_be    = hbe[host*BW +: BW];
        m_dwr   = hdwr[host*DW +: DW];
        m_cpu   = hcpu[host];
        delay   = $urandom_range(dmax, dmin);
      end
    end

    chk("busy", busy, in_acc);
    chk("rd_bus", rd_bus, in_acc && is_rd);
    chk("wr_bus", wr_bus, in_acc && !is_rd);
    chk("add_bus", add_bus, in_acc ? m_addr : '0);
    chk("byte_en", byte_en, in_acc ? m_be : '0);
    chk("data_bus_wr", data_bus_wr, in_acc ? m_dwr : '0);
    chk("cpu_bus", cpu_bus, in_acc ? m_cpu : 1'b0);
    chk("grant_id", grant_id, exp_gid);
    chk("hdone", hdone, exp_done ? (64'd1 << host) : 64'd0);
    chk("herr", herr, (exp_done && exp_err) ? (64'd1 << host) : 64'd0);
    chk("hdrd", hdrd, exp_hdrd);

    reset_n = (force_rst || $urandom_range(99) < rst_pct) ? 1'b0 : 1'b1;
    if (exp_done) begin
      hrd[host] = 1'b0;
      hwr[host] = 1'b0;
    end
    for (int i = 0; i < NH; i++) begin
      if (!(hrd[i] || hwr[i]) && !(exp_done && i == host) && $urandom_range(3) == 0) begin
        hrd[i] = $urandom_range(1);
        hwr[i] = !hrd[i] || ($urandom_range(7) == 0);
        haddr[i*AW +: AW] = $urandom;
        hbe[i*BW +: BW]   = BW'($urandom);
        hdwr[i*DW +: DW]  = $urandom;
        hcpu[i]           = $urandom_range(1);
      end
    end
    data_bus_rd = $urandom;
    if (in_acc) ack_bus = (n == delay);
    else        ack_bus = ($urandom_range(99) < stray_pct);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    hrd = '0; hwr = '0; hcpu = '0; haddr = '0; hbe = '0; hdwr = '0;
    req_mask = '1; tmo_limit = 16'd4; data_bus_rd = '0; ack_bus = 1'b0;
    foreach (grants[i]) grants[i] = 0;

    force_rst = 1;
    run(3);
    force_rst = 0;

    stray_pct = 10;
    run(400);
    chk("timeouts_seen", timeouts != 0, 1'b1);

    req_mask = 4'b1011;
    foreach (grants[i]) grants[i] = 0;
    run(200);
    chk("host2_masked_grants", grants[2], 0);
    chk("host0_masked_grants", grants[0] != 0, 1'b1);

    req_mask = '1;
    foreach (grants[i]) grants[i] = 0;
    run(100);
    chk("host2_unmasked_grants", grants[2] != 0, 1'b1);

    tmo_limit = 16'd0;
    dmin = 40; dmax = 40;
    timeouts = 0;
    run(150);
    chk("no_timeout_when_disabled", timeouts, 0);

    dmin = 1; dmax = 6;
    rst_pct = 2;
    for (int p = 0; p < 4; p++) begin
      tmo_limit = TW'(p + 1);
      run(100);
    end
    tmo_limit = 16'd5;
    run(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
